rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage; successor to the combinational RV32 decoder.
- Sits between fetch and execute, with valid/ready handshakes on both sides and a flush input for branch redirects.
- Fully decodes RV32I R/I/S/B/U/J formats: immediates, ALU op (incl. shifts/compare/xor), memory and control flags, and illegal-instruction detection.
- Computes the PC-relative branch/jump target.

Parameters:
- XLEN, 32, datapath and PC width; immediates are sign-extended to XLEN.
- ZERO_RD_WE, 1, when 1 force rd_we_o=0 if rd==x0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- flush_i  in  1  drop held and incoming instruction
- in_valid_i  in  1  fetch has instruction
- in_ready_o  out  1  stage can accept
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction PC
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  execute accepts bundle
- pc_o  out  XLEN  registered PC
- rs_addr_a_o  out  5  instr[19:15]
- rs_addr_b_o  out  5  instr[24:20]
- rd_addr_o  out  5  instr[11:7]
- imm_o  out  XLEN  format-selected sign-extended immediate
- alu_src_o  out  1  1 = ALU operand B is imm_o
- alu_ctrl_o  out  rv_pkg::alu_operations_e  ALU operation
- rd_we_o  out  1  register write enable
- mem_re_o  out  1  load
- mem_we_o  out  1  store
- branch_o  out  1  conditional branch
- jump_o  out  1  JAL/JALR
- branch_target_o  out  XLEN  pc_i+imm (JALR: 0, execute adds rs1)
- illegal_o  out  1  unsupported encoding

Behaviour:
- Reset (rst_ni low, async):
  - out_valid_o=0, alu_ctrl_o=OP_NOP, illegal_o=0.
  - All other outputs 0.
  - in_ready_o=1 once out_valid_o=0.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - Capture when in_valid_i && in_ready_o.
  - Latency is 1 cycle: the bundle is visible the cycle after capture.
- Output register holds the bundle stable while out_valid_o && !out_ready_i.
  - in_ready_o is 0 in that state.
  - No combinational path from instr_i to the outputs.
- out_valid_o next-state:
  - flush_i: 0 (highest priority, overrides a simultaneous capture).
  - Else capture: 1.
  - Else out_ready_i: 0.
  - Else hold.
- Flush while stalled: the held bundle is discarded; in_ready_o already reflects out_ready_i only.
- Immediate formats:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All sign-extended to XLEN.
- branch_target_o = pc_i + imm, truncated modulo 2^XLEN (wrap allowed, no flag).
- ALU op per opcode/funct3/funct7[5]:
  - LOAD/STORE/AUIPC/JAL/JALR: OP_ADD.
  - LUI: OP_ADD, rs_a forced 0.
  - BRANCH: OP_SUB for BEQ/BNE, OP_SLT for BLT/BGE, OP_SLTU for BLTU/BGEU.
  - OP: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
  - OP-IMM: same set; SUB not encodable; funct7[5] selects SRAI.
- alu_src_o = 1 for OP-IMM, LOAD, STORE, LUI, AUIPC.
- rd_we_o = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR; gated by ZERO_RD_WE for rd==x0.
- illegal_o = 1 for any of:
  - unknown opcode;
  - instr[1:0]!=2'b11;
  - OP with funct7 not in {0x00, 0x20 valid combos};
  - shift-imm with bad funct7.
- When illegal_o=1: rd_we/mem_re/mem_we/branch/jump forced 0 and alu_ctrl_o=OP_NOP; the bundle is still delivered with out_valid_o=1.

Optional Feature:
- Macro RV_DECODE_MULDIV_EN.
- Defined: OP with funct7=0x01 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU to OP_MUL..OP_REMU, with rd_we_o=1.
- Undefined: funct7=0x01 is flagged illegal_o=1.

Decomposition:
- rv_pkg gains:
  - opcode localparams (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC);
  - alu_operations_e extended with OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, plus the M-extension ops under the macro;
  - an imm_fmt_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J).
- Sub-module rv_imm_gen: combinational, instr and imm_fmt_e in, XLEN immediate out.
- Control decode stays inline.

Test Plan:
- add x3,x1,x2 (0x002081B3), pc 0x0 -> next cycle out_valid_o=1, rs_a=1, rs_b=2, rd=3, OP_ADD, alu_src_o=0, rd_we_o=1.
- addi x1,x0,-1 (0xFFF00093), then sub x5,x6,x7 (0x407302B3) back-to-back with out_ready_i=1 -> imm_o=0xFFFFFFFF, alu_src_o=1; next cycle OP_SUB, no bubble.
- beq x1,x2,-8 (0xFE208CE3) at pc 0x100 -> branch_o=1, OP_SUB, imm_o=0xFFFFFFF8, branch_target_o=0xF8, rd_we_o=0.
- Hold out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, bundle unchanged; release -> next instruction captured, with flush_i pulsed in the same cycle -> out_valid_o=0.
- 0x0000007F -> illegal_o=1, alu_ctrl_o=OP_NOP, all enables 0; addi x0,x0,1 -> rd_we_o=0.
- mul x3,x1,x2 (0x022081B3) -> OP_MUL, rd_we_o=1 with RV_DECODE_MULDIV_EN; illegal_o=1 without it.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU operations, and immediate formats.
// Build option RV_DECODE_MULDIV_EN adds the M-extension ALU operations.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_SLT,
    OP_SLTU
`ifdef RV_DECODE_MULDIV_EN
    ,
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU
`endif
  } alu_operations_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // funct3 mapping shared by OP and OP-IMM when funct7 carries no modifier.
  function automatic alu_operations_e base_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

`ifdef RV_DECODE_MULDIV_EN
  function automatic alu_operations_e muldiv_alu_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return OP_MUL;
      3'b001:  return OP_MULH;
      3'b010:  return OP_MULHSU;
      3'b011:  return OP_MULHU;
      3'b100:  return OP_DIV;
      3'b101:  return OP_DIVU;
      3'b110:  return OP_REM;
      default: return OP_REMU;
    endcase
  endfunction
`endif

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator: assembles the I/S/B/U/J immediate and
// sign-extends it to XLEN.
module rv_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic signed [31:0] imm32;

  // NOTE: assign a default before the case so no path leaves imm32 unassigned (no latch).
  always_comb begin
    imm32 = '0;
    case (fmt_i)
      IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      IMM_U: imm32 = {instr_i[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides and a flush input.
// Build option RV_DECODE_MULDIV_EN decodes OP funct7=0x01 as M-extension ops.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ZERO_RD_WE = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rs_addr_a_o,
  output logic [4:0]      rs_addr_b_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] imm_o,
  output logic            alu_src_o,
  output alu_operations_e alu_ctrl_o,
  output logic            rd_we_o,
  output logic            mem_re_o,
  output logic            mem_we_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic            illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       capture;

  imm_fmt_e        d_fmt;
  logic            d_has_imm;
  logic [XLEN-1:0] d_imm_raw;
  logic [XLEN-1:0] d_imm;
  logic [XLEN-1:0] d_target;
  alu_operations_e d_alu;
  logic d_src, d_we, d_re, d_wr, d_br, d_jp, d_ill, d_lui;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign capture = in_valid_i && in_ready_o;

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (instr_i[31:7]),
    .fmt_i   (d_fmt),
    .imm_o   (d_imm_raw)
  );

  always_comb begin
    d_fmt     = IMM_I;
    d_has_imm = 1'b1;
    d_alu     = OP_ADD;
    d_src     = 1'b0;
    d_we      = 1'b0;
    d_re      = 1'b0;
    d_wr      = 1'b0;
    d_br      = 1'b0;
    d_jp      = 1'b0;
    d_ill     = 1'b0;
    d_lui     = 1'b0;
    case (opcode)
      OPC_LOAD:   begin d_src = 1'b1; d_we = 1'b1; d_re = 1'b1; end
      OPC_STORE:  begin d_fmt = IMM_S; d_src = 1'b1; d_wr = 1'b1; end
      OPC_JAL:    begin d_fmt = IMM_J; d_we = 1'b1; d_jp = 1'b1; end
      OPC_JALR:   begin d_we = 1'b1; d_jp = 1'b1; end
      OPC_LUI:    begin d_fmt = IMM_U; d_src = 1'b1; d_we = 1'b1; d_lui = 1'b1; end
      OPC_AUIPC:  begin d_fmt = IMM_U; d_src = 1'b1; d_we = 1'b1; end
      OPC_BRANCH: begin
        d_fmt = IMM_B;
        d_br  = 1'b1;
        case (funct3[2:1])
          2'b10:   d_alu = OP_SLT;
          2'b11:   d_alu = OP_SLTU;
          default: d_alu = OP_SUB;
        endcase
      end
      OPC_OP_IMM: begin
        d_src = 1'b1;
        d_we  = 1'b1;
        d_alu = base_alu_op(funct3);
        // Shift-immediates reuse funct7: only SRAI may set bit 5.
        if (funct3 == 3'b001) begin
          d_ill = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'h20) d_alu = OP_SRA;
          else d_ill = (funct7 != 7'h00);
        end
      end
      OPC_OP: begin
        d_has_imm = 1'b0;
        d_we      = 1'b1;
        case (funct7)
          7'h00: d_alu = base_alu_op(funct3);
          7'h20: begin
            if (funct3 == 3'b000)      d_alu = OP_SUB;
            else if (funct3 == 3'b101) d_alu = OP_SRA;
            else                       d_ill = 1'b1;
          end
`ifdef RV_DECODE_MULDIV_EN
          7'h01:   d_alu = muldiv_alu_op(funct3);
`endif
          default: d_ill = 1'b1;
        endcase
      end
      default: begin
        d_has_imm = 1'b0;
        d_ill     = 1'b1;
      end
    endcase

    if (d_ill) begin
      d_alu = OP_NOP;
      d_we  = 1'b0;
      d_re  = 1'b0;
      d_wr  = 1'b0;
      d_br  = 1'b0;
      d_jp  = 1'b0;
    end
    if (ZERO_RD_WE && instr_i[11:7] == 5'd0) d_we = 1'b0;
  end

  assign d_imm    = d_has_imm ? d_imm_raw : '0;
  // JALR's base is rs1, which only execute can add; the stage reports 0 for it.
  assign d_target = (opcode == OPC_JALR) ? '0 : pc_i + d_imm;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o     <= 1'b0;
      pc_o            <= '0;
      rs_addr_a_o     <= '0;
      rs_addr_b_o     <= '0;
      rd_addr_o       <= '0;
      imm_o           <= '0;
      alu_src_o       <= 1'b0;
      alu_ctrl_o      <= OP_NOP;
      rd_we_o         <= 1'b0;
      mem_re_o        <= 1'b0;
      mem_we_o        <= 1'b0;
      branch_o        <= 1'b0;
      jump_o          <= 1'b0;
      branch_target_o <= '0;
      illegal_o       <= 1'b0;
    end else begin
      if (flush_i)          out_valid_o <= 1'b0;
      else if (capture)     out_valid_o <= 1'b1;
      else if (out_ready_i) out_valid_o <= 1'b0;

      if (capture) begin
        pc_o            <= pc_i;
        rs_addr_a_o     <= d_lui ? 5'd0 : instr_i[19:15];
        rs_addr_b_o     <= instr_i[24:20];
        rd_addr_o       <= instr_i[11:7];
        imm_o           <= d_imm;
        alu_src_o       <= d_src;
        alu_ctrl_o      <= d_alu;
        rd_we_o         <= d_we;
        mem_re_o        <= d_re;
        mem_we_o        <= d_wr;
        branch_o        <= d_br;
        jump_o          <= d_jp;
        branch_target_o <= d_target;
        illegal_o       <= d_ill;
      end
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: directed and random stimulus against a
// field-level reference decoder, with an independent output monitor.
module tb_rv_decode_stage;
  import rv_pkg::*;

  localparam int XLEN = 32;
  localparam logic [6:0] OPC_LIST [9] = '{OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
                                          OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC};

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            in_valid_i = 1'b0;
  logic            out_ready_i = 1'b0;
  logic [31:0]     instr_i = '0;
  logic [XLEN-1:0] pc_i = '0;
  logic            in_ready_o, out_valid_o;
  logic [XLEN-1:0] pc_o, imm_o, branch_target_o;
  logic [4:0]      rs_addr_a_o, rs_addr_b_o, rd_addr_o;
  logic            alu_src_o, rd_we_o, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o;
  alu_operations_e alu_ctrl_o;

  always #5 clk_i = ~clk_i;

  rv_decode_stage #(.XLEN(XLEN), .ZERO_RD_WE(1'b1)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .instr_i         (instr_i),
    .pc_i            (pc_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .pc_o            (pc_o),
    .rs_addr_a_o     (rs_addr_a_o),
    .rs_addr_b_o     (rs_addr_b_o),
    .rd_addr_o       (rd_addr_o),
    .imm_o           (imm_o),
    .alu_src_o       (alu_src_o),
    .alu_ctrl_o      (alu_ctrl_o),
    .rd_we_o         (rd_we_o),
    .mem_re_o        (mem_re_o),
    .mem_we_o        (mem_we_o),
    .branch_o        (branch_o),
    .jump_o          (jump_o),
    .branch_target_o (branch_target_o),
    .illegal_o       (illegal_o)
  );

  typedef struct {
    logic [31:0]     pc;
    logic [4:0]      rs_a, rs_b, rd;
    logic [31:0]     imm;
    logic            alu_src;
    alu_operations_e alu;
    logic            rd_we, mem_re, mem_we, branch, jump, illegal;
    logic [31:0]     target;
  } bundle_t;

  bundle_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference decoder built from the instruction-set rules, field by field.
  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    int s;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    alu_operations_e tbl [8];
    tbl = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
    s   = int'(ins);
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    b.pc = pc; b.rs_a = ins[19:15]; b.rs_b = ins[24:20]; b.rd = ins[11:7];
    b.imm = 0; b.alu_src = 0; b.alu = OP_ADD; b.rd_we = 0; b.mem_re = 0;
    b.mem_we = 0; b.branch = 0; b.jump = 0; b.illegal = 0;
    if (opc == OPC_LUI) b.rs_a = 0;
    if (opc == OPC_LOAD) begin
      b.imm = s >>> 20; b.alu_src = 1; b.rd_we = 1; b.mem_re = 1;
    end else if (opc == OPC_STORE) begin
      b.imm = ((s >>> 25) << 5) | int'(ins[11:7]); b.alu_src = 1; b.mem_we = 1;
    end else if (opc == OPC_BRANCH) begin
      b.imm = ((s >>> 31) << 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5)
            | (int'(ins[11:8]) << 1);
      b.branch = 1;
      if (f3 == 4 || f3 == 5)      b.alu = OP_SLT;
      else if (f3 == 6 || f3 == 7) b.alu = OP_SLTU;
      else                         b.alu = OP_SUB;
    end else if (opc == OPC_JAL) begin
      b.imm = ((s >>> 31) << 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11)
            | (int'(ins[30:21]) << 1);
      b.rd_we = 1; b.jump = 1;
    end else if (opc == OPC_JALR) begin
      b.imm = s >>> 20; b.rd_we = 1; b.jump = 1;
    end else if (opc == OPC_LUI || opc == OPC_AUIPC) begin
      b.imm = ins & 32'hFFFF_F000; b.alu_src = 1; b.rd_we = 1;
    end else if (opc == OPC_OP_IMM) begin
      b.imm = s >>> 20; b.alu_src = 1; b.rd_we = 1; b.alu = tbl[f3];
      if (f3 == 1 && f7 != 0) b.illegal = 1;
      if (f3 == 5 && f7 == 7'h20) b.alu = OP_SRA;
      else if (f3 == 5 && f7 != 0) b.illegal = 1;
    end else if (opc == OPC_OP) begin
      b.rd_we = 1;
      if (f7 == 0) b.alu = tbl[f3];
      else if (f7 == 7'h20 && f3 == 0) b.alu = OP_SUB;
      else if (f7 == 7'h20 && f3 == 5) b.alu = OP_SRA;
`ifdef RV_DECODE_MULDIV_EN
      else if (f7 == 7'h01) b.alu = alu_operations_e'(int'(OP_MUL) + int'(f3));
`endif
      else b.illegal = 1;
    end else begin
      b.illegal = 1;
    end
    if (b.illegal) begin
      b.alu = OP_NOP; b.rd_we = 0; b.mem_re = 0; b.mem_we = 0; b.branch = 0; b.jump = 0;
    end
    if (b.rd == 0) b.rd_we = 0;
    b.target = (opc == OPC_JALR) ? 32'd0 : pc + b.imm;
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = OPC_LIST[k];
    if (w[6:0] == OPC_OP || w[6:0] == OPC_OP_IMM) begin
      case ($urandom_range(0, 3))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        2:       w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // Applies one cycle of inputs, then advances the scoreboard for that edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    bit ready;
    in_valid_i = v; instr_i = ins; pc_i = pc; out_ready_i = rdy; flush_i = fl;
    @(posedge clk_i);
    #2;
    ready = (sb_q.size() == 0) || out_ready_i;
    if (flush_i) begin
      sb_q.delete();
    end else begin
      if (out_ready_i && sb_q.size() != 0) void'(sb_q.pop_front());
      if (in_valid_i && ready) sb_q.push_back(ref_decode(instr_i, pc_i));
    end
  endtask

  initial begin : monitor
    bundle_t e;
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        check("out_valid", 64'(out_valid_o), 64'(sb_q.size() != 0));
        check("in_ready", 64'(in_ready_o), 64'((sb_q.size() == 0) || out_ready_i));
        if (sb_q.size() != 0 && out_valid_o) begin
          e = sb_q[0];
          check("pc", 64'(pc_o), 64'(e.pc));
          check("rs_a", 64'(rs_addr_a_o), 64'(e.rs_a));
          check("rs_b", 64'(rs_addr_b_o), 64'(e.rs_b));
          check("rd", 64'(rd_addr_o), 64'(e.rd));
          check("imm", 64'(imm_o), 64'(e.imm));
          check("alu_src", 64'(alu_src_o), 64'(e.alu_src));
          check("alu_ctrl", 64'(alu_ctrl_o), 64'(e.alu));
          check("rd_we", 64'(rd_we_o), 64'(e.rd_we));
          check("mem_re", 64'(mem_re_o), 64'(e.mem_re));
          check("mem_we", 64'(mem_we_o), 64'(e.mem_we));
          check("branch", 64'(branch_o), 64'(e.branch));
          check("jump", 64'(jump_o), 64'(e.jump));
          check("target", 64'(branch_target_o), 64'(e.target));
          check("illegal", 64'(illegal_o), 64'(e.illegal));
        end
      end
    end
  end

  initial begin : stimulus
    #12;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_alu_ctrl", 64'(alu_ctrl_o), 64'(OP_NOP));
    check("rst_illegal", 64'(illegal_o), 64'd0);
    check("rst_pc", 64'(pc_o), 64'd0);
    check("rst_imm", 64'(imm_o), 64'd0);
    check("rst_target", 64'(branch_target_o), 64'd0);
    check("rst_rd_we", 64'(rd_we_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mon_en = 1'b1;

    step(1, 32'h002081B3, 32'h0000_0000, 1, 0);  // add x3,x1,x2
    step(1, 32'hFFF00093, 32'h0000_0004, 1, 0);  // addi x1,x0,-1
    step(1, 32'h407302B3, 32'h0000_0008, 1, 0);  // sub x5,x6,x7
    step(1, 32'hFE208CE3, 32'h0000_0100, 1, 0);  // beq x1,x2,-8
    step(1, 32'h00A00113, 32'h0000_0104, 0, 0);  // addi x2,x0,10, then stall
    repeat (3) step(1, 32'h0000007F, 32'h0000_0108, 0, 0);
    step(1, 32'h0000007F, 32'h0000_0108, 1, 1);  // release with flush
    step(1, 32'h0000007F, 32'h0000_010C, 1, 0);  // illegal opcode
    step(1, 32'h00100013, 32'h0000_0110, 1, 0);  // addi x0,x0,1
    step(1, 32'h022081B3, 32'h0000_0114, 1, 0);  // mul x3,x1,x2
    step(1, 32'h020000EF, 32'hFFFF_FFF0, 1, 0);  // jal x1,+32 wrapping target
    step(1, 32'h00000083, 32'h0000_0200, 1, 0);  // low bits ok, opcode LOAD
    step(1, 32'h00000082, 32'h0000_0204, 1, 0);  // instr[1:0]=10
    step(0, 32'h0, 32'h0, 1, 0);

    repeat (3000)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    repeat (3) step(0, 32'h0, 32'h0, 1, 0);

    // Reset asserted between edges must clear the held bundle immediately.
    step(1, 32'h002081B3, 32'h0000_0040, 0, 0);
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid_o), 64'd0);
    check("async_rst_alu_ctrl", 64'(alu_ctrl_o), 64'(OP_NOP));
    check("async_rst_rd_we", 64'(rd_we_o), 64'd0);
    check("async_rst_in_ready", 64'(in_ready_o), 64'd1);
    sb_q.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
